// File: rtl/door_access_sequencer_if.sv
// Door sequencer signal bundle: raw presence sensors and lock in,
// per-door servo commands and status out.
interface door_access_sequencer_if;
  logic       presence_1;
  logic       presence_2;
  logic       lock;
  logic       door_open_1;
  logic       door_open_2;
  logic       busy;
  logic [1:0] pending;
  logic       active_door;

  // Environment side: drives the sensors and lock, observes the commands.
  modport master (
    output presence_1, presence_2, lock,
    input  door_open_1, door_open_2, busy, pending, active_door
  );

  // Sequencer side.
  modport slave (
    input  presence_1, presence_2, lock,
    output door_open_1, door_open_2, busy, pending, active_door
  );
endinterface

// File: rtl/door_access_sequencer.sv
// Door access sequencer: synchronises and debounces the two presence
// sensors, latches requests and grants one door at a time round-robin.
// A granted door travels open, holds, travels closed and returns to IDLE;
// a detection of the owning door during hold restarts the hold, and during
// closing reopens the door. The two open commands are mutually exclusive.
module door_access_sequencer #(
  parameter int unsigned DEBOUNCE_CYC = 32'd500_000,
  parameter int unsigned TRAVEL_CYC   = 32'd25_000_000,
  parameter int unsigned HOLD_CYC     = 32'd125_000_000,
  parameter int unsigned CNT_W        = 32'd32
) (
  input logic                   clk,
  input logic                   rst_n,
  door_access_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 32'd1);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_OPEN_MOVE  = 2'd1,
    ST_HOLD       = 2'd2,
    ST_CLOSE_MOVE = 2'd3
  } state_e;

  // Sensor path, bit0 = door 1, bit1 = door 2, raw polarity (0 = detected).
  logic [1:0]            raw_s;
  logic [1:0]            sync1_r;
  logic [1:0]            sync2_r;
  logic [1:0]            deb_r;
  logic [1:0]            deb_nxt_s;
  logic [1:0][CNT_W-1:0] deb_cnt_r;
  logic [1:0][CNT_W-1:0] deb_cnt_nxt_s;
  logic [1:0]            det_s;
  logic [1:0]            det_nxt_s;

  // Sequencer state.
  state_e     state_r;
  state_e     state_nxt_s;
  logic [CNT_W-1:0] timer_r;
  logic [CNT_W-1:0] timer_nxt_s;
  logic [1:0] door_r;
  logic [1:0] door_nxt_s;
  logic       active_r;
  logic       active_nxt_s;
  logic       last_r;
  logic       last_nxt_s;
  logic [1:0] pending_r;
  logic [1:0] pending_nxt_s;
  logic [1:0] grant_s;
  logic       pick_s;
  logic       busy_r;

  assign raw_s     = {bus.presence_2, bus.presence_1};
  assign det_s     = ~deb_r;
  assign det_nxt_s = ~deb_nxt_s;

  // Two-flop synchroniser per sensor; idles at "absent" (high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: adopt the synchronised level after DEBOUNCE_CYC consecutive differing cycles.
  always_comb begin
    deb_nxt_s     = deb_r;
    deb_cnt_nxt_s = deb_cnt_r;
    for (int i = 0; i < 2; i++) begin
      if (sync2_r[i] != deb_r[i]) begin
        if (deb_cnt_r[i] == DEB_LAST) begin
          deb_nxt_s[i]     = sync2_r[i];
          deb_cnt_nxt_s[i] = '0;
        end else begin
          deb_cnt_nxt_s[i] = deb_cnt_r[i] + ONE;
        end
      end else begin
        deb_cnt_nxt_s[i] = '0;
      end
    end
  end

  // Debounced level and run-length counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r     <= 2'b11;
      deb_cnt_r <= '0;
    end else begin
      deb_r     <= deb_nxt_s;
      deb_cnt_r <= deb_cnt_nxt_s;
    end
  end

  // Next-state, timer, command and request logic for the door FSM.
  always_comb begin
    state_nxt_s  = state_r;
    timer_nxt_s  = timer_r + ONE;
    door_nxt_s   = door_r;
    active_nxt_s = active_r;
    last_nxt_s   = last_r;
    grant_s      = 2'b00;
    // With both doors waiting, serve the one not served last.
    if (pending_r == 2'b11) begin
      pick_s = ~last_r;
    end else begin
      pick_s = pending_r[1];
    end

    case (state_r)
      ST_IDLE: begin
        timer_nxt_s = '0;
        door_nxt_s  = 2'b00;
        if (!bus.lock && (pending_r != 2'b00)) begin
          state_nxt_s   = ST_OPEN_MOVE;
          active_nxt_s  = pick_s;
          grant_s[pick_s] = 1'b1;
          door_nxt_s    = pick_s ? 2'b10 : 2'b01;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OPEN_MOVE: begin
        if (timer_r == TRAVEL_LAST) begin
          state_nxt_s = ST_HOLD;
          timer_nxt_s = '0;
        end else begin
          state_nxt_s = ST_OPEN_MOVE;
        end
      end
      ST_HOLD: begin
        // Someone still at the owning door keeps it open regardless of lock.
        if (det_s[active_r]) begin
          timer_nxt_s = '0;
        end else if (timer_r == HOLD_LAST) begin
          state_nxt_s = ST_CLOSE_MOVE;
          timer_nxt_s = '0;
          door_nxt_s  = 2'b00;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_CLOSE_MOVE: begin
        // Reopen on a fresh detection while closing; lock does not block this.
        if (det_s[active_r]) begin
          state_nxt_s = ST_OPEN_MOVE;
          timer_nxt_s = '0;
          door_nxt_s  = active_r ? 2'b10 : 2'b01;
        end else if (timer_r == TRAVEL_LAST) begin
          state_nxt_s = ST_IDLE;
          timer_nxt_s = '0;
          last_nxt_s  = active_r;
        end else begin
          state_nxt_s = ST_CLOSE_MOVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        timer_nxt_s = '0;
        door_nxt_s  = 2'b00;
      end
    endcase

    // Requests latch while detected and drop only in their grant cycle.
    pending_nxt_s = pending_r;
    for (int i = 0; i < 2; i++) begin
      if (grant_s[i]) begin
        pending_nxt_s[i] = 1'b0;
      end else begin
        pending_nxt_s[i] = pending_r[i] | det_nxt_s[i];
      end
    end
  end

  // FSM state, shared timer, registered outputs and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      timer_r   <= '0;
      door_r    <= 2'b00;
      active_r  <= 1'b0;
      last_r    <= 1'b1;
      pending_r <= 2'b00;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      door_r    <= door_nxt_s;
      active_r  <= active_nxt_s;
      last_r    <= last_nxt_s;
      pending_r <= pending_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.door_open_1 = door_r[0];
  assign bus.door_open_2 = door_r[1];
  assign bus.busy        = busy_r;
  assign bus.pending     = pending_r;
  assign bus.active_door = active_r;

endmodule

// File: tb/tb_door_access_sequencer.sv
// Directed bench for door_access_sequencer with short timing parameters
// (debounce 4, travel 8, hold 16). Edge numbers in comments count rising
// edges after the stimulus change, which is applied 1 ns after an edge.
module tb_door_access_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   overlap_cnt = 0;

  door_access_sequencer_if bus();

  door_access_sequencer #(
    .DEBOUNCE_CYC(32'd4),
    .TRAVEL_CYC  (32'd8),
    .HOLD_CYC    (32'd16),
    .CNT_W       (32'd32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Interlock watch over the whole run.
  always @(negedge clk) begin
    if (bus.door_open_1 === 1'b1 && bus.door_open_2 === 1'b1) overlap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.presence_1 = 1'b1;
    bus.presence_2 = 1'b1;
    bus.lock       = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((bus.busy !== 1'b0 || bus.pending !== 2'b00) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) $display("FAIL %s_quiet: busy=%b pending=%b, required idle with no requests within 400 cycles", name, bus.busy, bus.pending);
    else passes++;
  endtask

  task automatic test_reset();
    bus.presence_1 = 1'b1;
    bus.presence_2 = 1'b1;
    bus.lock       = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (bus.door_open_1 !== 1'b0) $display("FAIL rst_open1: got %b want 0", bus.door_open_1); else passes++;
    checks++; if (bus.door_open_2 !== 1'b0) $display("FAIL rst_open2: got %b want 0", bus.door_open_2); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.pending !== 2'b00) $display("FAIL rst_pending: got %b want 00", bus.pending); else passes++;
    checks++; if (bus.active_door !== 1'b0) $display("FAIL rst_active: got %b want 0", bus.active_door); else passes++;
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", bus.busy); else passes++;
  endtask

  task automatic test_single();
    apply_reset();
    bus.presence_1 = 1'b0;
    repeat (5) tick();                       // edge 5
    checks++; if (bus.pending !== 2'b00) $display("FAIL single_pend_early: got %b want 00", bus.pending); else passes++;
    tick();                                  // edge 6: debounced
    checks++; if (bus.pending !== 2'b01) $display("FAIL single_pend_set: got %b want 01", bus.pending); else passes++;
    checks++; if (bus.door_open_1 !== 1'b0) $display("FAIL single_open_early: got %b want 0", bus.door_open_1); else passes++;
    bus.presence_1 = 1'b1;
    tick();                                  // edge 7: granted
    checks++; if (bus.door_open_1 !== 1'b1) $display("FAIL single_open_rise: got %b want 1", bus.door_open_1); else passes++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else passes++;
    checks++; if (bus.active_door !== 1'b0) $display("FAIL single_active: got %b want 0", bus.active_door); else passes++;
    repeat (23) tick();                      // edge 30
    checks++; if (bus.door_open_1 !== 1'b1) $display("FAIL single_open_last: got %b want 1", bus.door_open_1); else passes++;
    tick();                                  // edge 31: closing
    checks++; if (bus.door_open_1 !== 1'b0) $display("FAIL single_open_fall: got %b want 0", bus.door_open_1); else passes++;
    repeat (7) tick();                       // edge 38
    checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy_close: got %b want 1", bus.busy); else passes++;
    tick();                                  // edge 39: idle
    checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", bus.busy); else passes++;
    wait_quiet("single");
  endtask

  task automatic test_both();
    apply_reset();
    bus.presence_1 = 1'b0;
    bus.presence_2 = 1'b0;
    repeat (6) tick();                       // edge 6
    checks++; if (bus.pending !== 2'b11) $display("FAIL both_pend: got %b want 11", bus.pending); else passes++;
    bus.presence_1 = 1'b1;
    bus.presence_2 = 1'b1;
    tick();                                  // edge 7
    checks++; if ({bus.door_open_2, bus.door_open_1} !== 2'b01) $display("FAIL both_first: got %b want 01", {bus.door_open_2, bus.door_open_1}); else passes++;
    repeat (32) tick();                      // edge 39: one idle cycle
    checks++; if (bus.busy !== 1'b0) $display("FAIL both_gap_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.pending !== 2'b11) $display("FAIL both_gap_pend: got %b want 11", bus.pending); else passes++;
    checks++; if (bus.door_open_2 !== 1'b0) $display("FAIL both_gap_open2: got %b want 0", bus.door_open_2); else passes++;
    tick();                                  // edge 40: door 2 granted
    checks++; if (bus.door_open_2 !== 1'b1) $display("FAIL both_second: got %b want 1", bus.door_open_2); else passes++;
    checks++; if (bus.active_door !== 1'b1) $display("FAIL both_active2: got %b want 1", bus.active_door); else passes++;
    wait_quiet("both");
    checks++; if (overlap_cnt !== 0) $display("FAIL both_interlock: got %0d overlapping cycles want 0", overlap_cnt); else passes++;
  endtask

  task automatic test_glitch();
    int seen;
    apply_reset();
    seen = 0;
    bus.presence_2 = 1'b0;
    repeat (3) tick();
    bus.presence_2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.door_open_2 !== 1'b0 || bus.pending !== 2'b00) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL glitch_filtered: got %0d reacting cycles want 0", seen); else passes++;
  endtask

  task automatic test_reopen();
    int busy_drop;
    apply_reset();
    bus.presence_1 = 1'b0;
    repeat (6) tick();
    bus.presence_1 = 1'b1;
    repeat (25) tick();                      // edge 31 = E: closing starts
    checks++; if (bus.door_open_1 !== 1'b0) $display("FAIL reopen_closing: got %b want 0", bus.door_open_1); else passes++;
    busy_drop = 0;
    bus.presence_1 = 1'b0;
    repeat (4) begin tick(); if (bus.busy !== 1'b1) busy_drop++; end
    bus.presence_1 = 1'b1;
    repeat (2) begin tick(); if (bus.busy !== 1'b1) busy_drop++; end   // E+6
    checks++; if (bus.door_open_1 !== 1'b0) $display("FAIL reopen_early: got %b want 0", bus.door_open_1); else passes++;
    tick();                                  // E+7: reopened
    checks++; if (bus.door_open_1 !== 1'b1) $display("FAIL reopen_rise: got %b want 1", bus.door_open_1); else passes++;
    checks++; if (busy_drop !== 0) $display("FAIL reopen_no_idle: got %0d idle cycles want 0", busy_drop); else passes++;
    repeat (23) tick();                      // E+30
    checks++; if (bus.door_open_1 !== 1'b1) $display("FAIL reopen_full_hold: got %b want 1", bus.door_open_1); else passes++;
    tick();                                  // E+31
    checks++; if (bus.door_open_1 !== 1'b0) $display("FAIL reopen_close: got %b want 0", bus.door_open_1); else passes++;
    wait_quiet("reopen");
  endtask

  task automatic test_lock();
    apply_reset();
    bus.presence_1 = 1'b0;
    repeat (6) tick();
    bus.presence_1 = 1'b1;
    repeat (10) tick();                      // edge 16: door 1 holding
    bus.lock = 1'b1;
    bus.presence_2 = 1'b0;
    repeat (6) tick();                       // edge 22
    bus.presence_2 = 1'b1;
    checks++; if (bus.pending[1] !== 1'b1) $display("FAIL lock_pend2: got %b want 1", bus.pending[1]); else passes++;
    repeat (23) tick();                      // edge 45: door 1 closed, locked in idle
    checks++; if (bus.busy !== 1'b0) $display("FAIL lock_idle: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.pending[1] !== 1'b1) $display("FAIL lock_pend_hold: got %b want 1", bus.pending[1]); else passes++;
    checks++; if ({bus.door_open_2, bus.door_open_1} !== 2'b00) $display("FAIL lock_closed: got %b want 00", {bus.door_open_2, bus.door_open_1}); else passes++;
    bus.lock = 1'b0;
    tick();                                  // edge 46
    checks++; if (bus.door_open_2 !== 1'b1) $display("FAIL lock_release_grant: got %b want 1", bus.door_open_2); else passes++;
    checks++; if (bus.active_door !== 1'b1) $display("FAIL lock_release_active: got %b want 1", bus.active_door); else passes++;
    wait_quiet("lock");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.presence_1 = 1'b0;
    repeat (6) tick();
    bus.presence_1 = 1'b1;
    repeat (14) tick();                      // edge 20: holding
    checks++; if (bus.door_open_1 !== 1'b1) $display("FAIL midrst_pre: got %b want 1", bus.door_open_1); else passes++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.door_open_1 !== 1'b0) $display("FAIL midrst_open: got %b want 0", bus.door_open_1); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.pending !== 2'b00) $display("FAIL midrst_pending: got %b want 00", bus.pending); else passes++;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_idle: got %b want 0", bus.busy); else passes++;
    checks++; if (bus.door_open_1 !== 1'b0) $display("FAIL midrst_after_open: got %b want 0", bus.door_open_1); else passes++;
  endtask

  initial begin
    bus.presence_1 = 1'b1;
    bus.presence_2 = 1'b1;
    bus.lock       = 1'b0;
    test_reset();
    test_single();
    test_both();
    test_glitch();
    test_reopen();
    test_lock();
    test_reset_mid();
    checks++; if (overlap_cnt !== 0) $display("FAIL interlock_total: got %0d overlapping cycles want 0", overlap_cnt); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
